// File: rtl/judge_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | judge_pkg: shared constants for the answer judge and its LFSR.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package judge_pkg;
   localparam int         WIN_SCORE_DEF = 5;
   localparam int         ANS_W_DEF     = 4;
   localparam logic [1:0] PLAYER_NONE   = 2'd0;
   localparam logic [1:0] PLAYER_P1     = 2'd1;
   localparam logic [1:0] PLAYER_P2     = 2'd2;
   localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
   localparam logic [7:0] LFSR_SEED     = 8'hA5;
endpackage
`default_nettype wire

// File: rtl/question_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | question_lfsr: 8-bit free-running Fibonacci LFSR for operands.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module question_lfsr
   import judge_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [7:0] o_lfsr
);
   logic [7:0] r_lfsr;
   logic       w_fb;

   assign w_fb   = ^(r_lfsr & LFSR_TAPS);
   assign o_lfsr = r_lfsr;

   always_ff @(posedge clk) begin
      if (!reset_n) r_lfsr <= SEED;
      else          r_lfsr <= {r_lfsr[6:0], w_fb};
   end
endmodule
`default_nettype wire

// File: rtl/round_judge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | round_judge: question generation, submission arbitration, answer |
// | judging and saturating scorekeeping for a two-player quiz.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module round_judge
   import judge_pkg::*;
#(
   parameter int         WIN_SCORE = WIN_SCORE_DEF,
   parameter int         ANS_W     = ANS_W_DEF,
   parameter logic [7:0] SEED      = LFSR_SEED
) (
   input  logic             clk_100mhz,
   input  logic             reset_n,
   input  logic             new_question,
   input  logic             accept_en,
   input  logic             clear_scores,
   input  logic             p1_btn_event,
   input  logic             p2_btn_event,
   input  logic [ANS_W-1:0] p1_answer,
   input  logic [ANS_W-1:0] p2_answer,
   output logic             p1_submit_event,
   output logic             p2_submit_event,
   output logic [ANS_W-2:0] operand_a,
   output logic [ANS_W-2:0] operand_b,
   output logic             is_ans_correct,
   output logic             is_game_over,
   output logic [3:0]       p1_score,
   output logic [3:0]       p2_score,
   output logic [1:0]       last_winner
);
   localparam int         c_OPW = ANS_W - 1;
   localparam logic [3:0] c_WIN = 4'(WIN_SCORE);

   logic [7:0]       w_lfsr;
   logic             w_unused_lfsr;
   logic [c_OPW-1:0] r_op_a, r_op_b;
   logic [ANS_W-1:0] r_expected;
   logic             r_q_open, r_ans_ok, r_over, r_tie_prio;
   logic             r_p1_sub, r_p2_sub;
   logic [3:0]       r_p1_score, r_p2_score;
   logic [1:0]       r_winner;

   logic             w_can, w_acc_p1, w_acc_p2, w_acc, w_tie, w_correct;
   logic [ANS_W-1:0] w_ans;
   logic [3:0]       w_p1_next, w_p2_next;

   question_lfsr #(.SEED(SEED)) u_lfsr (
      .clk     (clk_100mhz),
      .reset_n (reset_n),
      .o_lfsr  (w_lfsr)
   );
   assign w_unused_lfsr = ^w_lfsr;

   // Housekeeping pulses in the same cycle swallow any press.
   assign w_can    = r_q_open & accept_en & ~r_over & ~clear_scores & ~new_question;
   assign w_tie    = w_can & p1_btn_event & p2_btn_event;
   assign w_acc_p1 = w_can & p1_btn_event & (~p2_btn_event | ~r_tie_prio);
   assign w_acc_p2 = w_can & p2_btn_event & (~p1_btn_event |  r_tie_prio);
   assign w_acc    = w_acc_p1 | w_acc_p2;
   assign w_ans    = w_acc_p1 ? p1_answer : p2_answer;
   assign w_correct = (w_ans == r_expected);

   assign w_p1_next = (w_acc_p1 && w_correct && r_p1_score < c_WIN) ? r_p1_score + 4'd1 : r_p1_score;
   assign w_p2_next = (w_acc_p2 && w_correct && r_p2_score < c_WIN) ? r_p2_score + 4'd1 : r_p2_score;

   always_ff @(posedge clk_100mhz) begin
      if (!reset_n) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_expected <= '0;
         r_q_open   <= 1'b0;
         r_ans_ok   <= 1'b0;
         r_over     <= 1'b0;
         r_tie_prio <= 1'b0;
         r_p1_sub   <= 1'b0;
         r_p2_sub   <= 1'b0;
         r_p1_score <= 4'd0;
         r_p2_score <= 4'd0;
         r_winner   <= PLAYER_NONE;
      end else begin
         r_p1_sub <= w_acc_p1;
         r_p2_sub <= w_acc_p2;
         if (w_tie) r_tie_prio <= ~r_tie_prio;
         if (clear_scores) begin
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_over     <= 1'b0;
            r_winner   <= PLAYER_NONE;
            r_ans_ok   <= 1'b0;
            r_q_open   <= 1'b0;
         end else if (new_question) begin
            r_op_a     <= w_lfsr[c_OPW-1:0];
            r_op_b     <= w_lfsr[2*c_OPW-1:c_OPW];
            r_expected <= {1'b0, w_lfsr[c_OPW-1:0]} + {1'b0, w_lfsr[2*c_OPW-1:c_OPW]};
            r_q_open   <= 1'b1;
            r_ans_ok   <= 1'b0;
         end else if (w_acc) begin
            r_q_open   <= 1'b0;
            r_ans_ok   <= w_correct;
            r_p1_score <= w_p1_next;
            r_p2_score <= w_p2_next;
            if (w_p1_next == c_WIN) begin
               r_over   <= 1'b1;
               r_winner <= PLAYER_P1;
            end else if (w_p2_next == c_WIN) begin
               r_over   <= 1'b1;
               r_winner <= PLAYER_P2;
            end
         end
      end
   end

   assign p1_submit_event = r_p1_sub;
   assign p2_submit_event = r_p2_sub;
   assign operand_a       = r_op_a;
   assign operand_b       = r_op_b;
   assign is_ans_correct  = r_ans_ok;
   assign is_game_over    = r_over;
   assign p1_score        = r_p1_score;
   assign p2_score        = r_p2_score;
   assign last_winner     = r_winner;
endmodule
`default_nettype wire

// File: tb/tb_round_judge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_round_judge: directed self-checking bench for round_judge.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_round_judge;
   logic       clk_100mhz = 1'b0;
   logic       reset_n = 1'b0;
   logic       new_question = 1'b0, accept_en = 1'b0, clear_scores = 1'b0;
   logic       p1_btn_event = 1'b0, p2_btn_event = 1'b0;
   logic [3:0] p1_answer = 4'd0, p2_answer = 4'd0;
   logic       p1_submit_event, p2_submit_event, is_ans_correct, is_game_over;
   logic [2:0] operand_a, operand_b;
   logic [3:0] p1_score, p2_score;
   logic [1:0] last_winner;

   int         n_vec = 0;
   int         n_err = 0;

   // Reference LFSR and operand capture, built from the published equation.
   logic [7:0] m_lfsr;
   logic [2:0] m_a = 3'd0, m_b = 3'd0;
   logic [3:0] m_sum;
   assign m_sum = {1'b0, m_a} + {1'b0, m_b};

   always #5 clk_100mhz = ~clk_100mhz;

   always @(posedge clk_100mhz) begin
      if (!reset_n) m_lfsr <= 8'hA5;
      else begin
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         if (new_question && !clear_scores) begin
            m_a <= m_lfsr[2:0];
            m_b <= m_lfsr[5:3];
         end
      end
   end

   round_judge dut (
      .clk_100mhz      (clk_100mhz),
      .reset_n         (reset_n),
      .new_question    (new_question),
      .accept_en       (accept_en),
      .clear_scores    (clear_scores),
      .p1_btn_event    (p1_btn_event),
      .p2_btn_event    (p2_btn_event),
      .p1_answer       (p1_answer),
      .p2_answer       (p2_answer),
      .p1_submit_event (p1_submit_event),
      .p2_submit_event (p2_submit_event),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .is_ans_correct  (is_ans_correct),
      .is_game_over    (is_game_over),
      .p1_score        (p1_score),
      .p2_score        (p2_score),
      .last_winner     (last_winner)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock edge, then settle just past it; pulse inputs drop afterwards.
   task automatic tick();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic idle_inputs();
      new_question = 1'b0;
      clear_scores = 1'b0;
      p1_btn_event = 1'b0;
      p2_btn_event = 1'b0;
   endtask

   task automatic open_q();
      new_question = 1'b1;
      tick();
      idle_inputs();
   endtask

   task automatic press(input logic p1, input logic p2, input logic right);
      p1_answer    = right ? m_sum : m_sum + 4'd1;
      p2_answer    = right ? m_sum : m_sum + 4'd1;
      p1_btn_event = p1;
      p2_btn_event = p2;
      tick();
      idle_inputs();
   endtask

   initial begin
      tick();
      tick();
      chk("rst_p1_score", p1_score, 0);
      chk("rst_over", is_game_over, 0);
      chk("rst_winner", last_winner, 0);
      chk("rst_opa", operand_a, 0);
      chk("rst_sub", {p1_submit_event, p2_submit_event, is_ans_correct}, 0);
      reset_n   = 1'b1;
      accept_en = 1'b1;

      open_q();
      chk("q1_opa", operand_a, 5);
      chk("q1_opb", operand_b, 4);
      p1_answer = 4'd9; p1_btn_event = 1'b1;
      tick(); idle_inputs();
      chk("q1_p1_sub", p1_submit_event, 1);
      chk("q1_p2_sub", p2_submit_event, 0);
      chk("q1_correct", is_ans_correct, 1);
      chk("q1_p1_score", p1_score, 1);
      press(1'b1, 1'b0, 1'b1);
      chk("second_press_sub", p1_submit_event, 0);
      chk("second_press_score", p1_score, 1);

      open_q();
      chk("q2_opa_model", operand_a, m_a);
      chk("q2_opb_model", operand_b, m_b);
      press(1'b0, 1'b1, 1'b0);
      chk("wrong_p2_sub", p2_submit_event, 1);
      chk("wrong_correct", is_ans_correct, 0);
      chk("wrong_scores", {p1_score, p2_score}, {4'd1, 4'd0});

      open_q();
      press(1'b1, 1'b1, 1'b1);
      chk("tie1_subs", {p1_submit_event, p2_submit_event}, 2'b10);
      chk("tie1_scores", {p1_score, p2_score}, {4'd2, 4'd0});
      open_q();
      press(1'b1, 1'b1, 1'b1);
      chk("tie2_subs", {p1_submit_event, p2_submit_event}, 2'b01);
      chk("tie2_scores", {p1_score, p2_score}, {4'd2, 4'd1});

      open_q();
      accept_en = 1'b0;
      press(1'b1, 1'b0, 1'b1);
      chk("no_accept_sub", p1_submit_event, 0);
      accept_en = 1'b1;
      new_question = 1'b1;
      p1_answer = 4'd0; p1_btn_event = 1'b1;
      tick(); idle_inputs();
      chk("newq_press_sub", p1_submit_event, 0);
      press(1'b1, 1'b0, 1'b1);
      chk("after_newq_sub", p1_submit_event, 1);
      chk("after_newq_score", p1_score, 3);

      open_q();
      press(1'b1, 1'b0, 1'b1);
      chk("round4_over", is_game_over, 0);
      open_q();
      press(1'b1, 1'b0, 1'b1);
      chk("win_sub", p1_submit_event, 1);
      chk("win_over", is_game_over, 1);
      chk("win_winner", last_winner, 1);
      chk("win_score", p1_score, 5);
      open_q();
      press(1'b1, 1'b0, 1'b1);
      chk("post_win_sub", p1_submit_event, 0);
      chk("post_win_score", p1_score, 5);
      clear_scores = 1'b1;
      tick(); idle_inputs();
      chk("clear_scores", {p1_score, p2_score}, 0);
      chk("clear_over", {is_game_over, last_winner}, 0);

      for (int r = 0; r < 3; r++) begin
         open_q();
         press(1'b1, 1'b0, 1'b1);
      end
      chk("pre_reset_score", p1_score, 3);
      reset_n = 1'b0;
      tick();
      chk("mid_rst_score", p1_score, 0);
      chk("mid_rst_ops", {operand_a, operand_b}, 0);
      chk("mid_rst_flags", {is_ans_correct, is_game_over, last_winner}, 0);
      reset_n = 1'b1;
      open_q();
      chk("mid_rst_opa", operand_a, 5);
      chk("mid_rst_opb", operand_b, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
